// File: rtl/cube_pkg.sv
// Shared face indices, colour codes, palette values and net layout for the cube renderer.
package cube_pkg;

   localparam logic [2:0] FACE_U = 3'd0;
   localparam logic [2:0] FACE_L = 3'd1;
   localparam logic [2:0] FACE_F = 3'd2;
   localparam logic [2:0] FACE_R = 3'd3;
   localparam logic [2:0] FACE_B = 3'd4;
   localparam logic [2:0] FACE_D = 3'd5;

   localparam logic [2:0] C_WHITE  = 3'b000;
   localparam logic [2:0] C_ORANGE = 3'b001;
   localparam logic [2:0] C_GREEN  = 3'b010;
   localparam logic [2:0] C_RED    = 3'b011;
   localparam logic [2:0] C_BLUE   = 3'b100;
   localparam logic [2:0] C_YELLOW = 3'b101;

   localparam logic [23:0] RGB_WHITE  = 24'hFFFFFF;
   localparam logic [23:0] RGB_ORANGE = 24'hFF4000;
   localparam logic [23:0] RGB_GREEN  = 24'h00FF00;
   localparam logic [23:0] RGB_RED    = 24'hFF0000;
   localparam logic [23:0] RGB_BLUE   = 24'h0000FF;
   localparam logic [23:0] RGB_YELLOW = 24'hFFFF00;
   localparam logic [23:0] RGB_ERR    = 24'hFF00FF;

   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
      logic fs;
   } beam_t;

   localparam beam_t BEAM_RST = '{active: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

   typedef struct packed {
      logic       ok;
      logic [2:0] face;
   } face_t;

   // Cross layout: U above F, L/F/R/B across the middle row, D below F.
   function automatic face_t face_at(input logic [1:0] gx, input logic [1:0] gy);
      face_t r;
      r = '{ok: 1'b1, face: FACE_U};
      case ({gy, gx})
         4'b00_01: r.face = FACE_U;
         4'b01_00: r.face = FACE_L;
         4'b01_01: r.face = FACE_F;
         4'b01_10: r.face = FACE_R;
         4'b01_11: r.face = FACE_B;
         4'b10_01: r.face = FACE_D;
         default:  r = '{ok: 1'b0, face: FACE_U};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cube_palette.sv
// Final pipeline stage: registered colour-code to RGB lookup with background and blanking overrides.
module cube_palette #(
   parameter logic [23:0] BG_RGB = 24'h000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  code,
   input  logic        force_bg,
   input  logic        blank,
   output logic [23:0] rgb
);
   import cube_pkg::*;

   logic [23:0] lut;

   always_comb begin
      case (code)
         C_WHITE:  lut = RGB_WHITE;
         C_ORANGE: lut = RGB_ORANGE;
         C_GREEN:  lut = RGB_GREEN;
         C_RED:    lut = RGB_RED;
         C_BLUE:   lut = RGB_BLUE;
         C_YELLOW: lut = RGB_YELLOW;
         default:  lut = RGB_ERR;
      endcase
   end

   // Blanking wins over background so the DAC sees true black outside active video.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          rgb <= '0;
      else if (blank)    rgb <= '0;
      else if (force_bg) rgb <= BG_RGB;
      else               rgb <= lut;
   end

endmodule

// File: rtl/cube_net_renderer.sv
// Streams the 54-sticker cube net straight from beam position with a per-frame colour snapshot.
module cube_net_renderer #(
   parameter int          H_ACTIVE      = 640,
   parameter int          H_FP          = 16,
   parameter int          H_SYNC        = 96,
   parameter int          H_BP          = 48,
   parameter int          V_ACTIVE      = 480,
   parameter int          V_FP          = 10,
   parameter int          V_SYNC        = 2,
   parameter int          V_BP          = 33,
   parameter int          CELL_PX       = 10,
   parameter int          STICKER_CELLS = 2,
   parameter int          GAP_CELLS     = 1,
   parameter int          ORIGIN_X      = 2,
   parameter int          ORIGIN_Y      = 2,
   parameter logic [23:0] BG_RGB        = 24'h000000,
   parameter int          BLINK_FRAMES  = 30
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [161:0] color,
   input  logic         hl_en,
   input  logic [2:0]   hl_face,
   output logic [7:0]   VGA_R,
   output logic [7:0]   VGA_G,
   output logic [7:0]   VGA_B,
   output logic         VGA_HS,
   output logic         VGA_VS,
   output logic         VGA_BLANK_N,
   output logic         VGA_SYNC_N,
   output logic         VGA_CLK,
   output logic         frame_start
);
   import cube_pkg::*;

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int CW      = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
   localparam int FW      = $clog2(BLINK_FRAMES + 1);
   localparam int PITCH   = STICKER_CELLS + GAP_CELLS;
   localparam int FPITCH  = 3 * PITCH + GAP_CELLS;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] SUB_LAST = CW'(CELL_PX - 1);
   localparam logic [FW-1:0] F_LAST   = FW'(BLINK_FRAMES - 1);

   // Returns {valid, face grid index, sticker index} for one axis of a net-relative cell.
   function automatic logic [4:0] axis_dec(input int c);
      int g, f, s;
      g = 0;
      for (int i = 1; i < 4; i++) if (c >= i * FPITCH) g = i;
      f = c - g * FPITCH;
      s = 0;
      for (int i = 1; i < 3; i++) if (f >= i * PITCH) s = i;
      return {(c >= 0) && (f < 3 * PITCH) && (f - s * PITCH < STICKER_CELLS), 2'(g), 2'(s)};
   endfunction

   logic [HW-1:0] h, hc;
   logic [VW-1:0] v, vc;
   logic [CW-1:0] hsub, vsub;
   logic          h_last, v_last;

   assign h_last = (h == H_LAST);
   assign v_last = (v == V_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h <= '0; hc <= '0; hsub <= '0;
         v <= '0; vc <= '0; vsub <= '0;
      end else if (h_last) begin
         h <= '0; hc <= '0; hsub <= '0;
         if (v_last) begin
            v <= '0; vc <= '0; vsub <= '0;
         end else begin
            v <= v + 1'b1;
            if (vsub == SUB_LAST) begin vsub <= '0; vc <= vc + 1'b1; end
            else vsub <= vsub + 1'b1;
         end
      end else begin
         h <= h + 1'b1;
         if (hsub == SUB_LAST) begin hsub <= '0; hc <= hc + 1'b1; end
         else hsub <= hsub + 1'b1;
      end
   end

   beam_t beam_now;
   always_comb begin
      beam_now.active = (h < H_ACT) && (v < V_ACT);
      beam_now.hs     = !((h >= HS_BEG) && (h < HS_END));
      beam_now.vs     = !((v >= VS_BEG) && (v < VS_END));
      beam_now.fs     = (h == '0) && (v == '0);
   end

   // Snapshot inputs and the pre-update blink phase once per frame so a frame never tears.
   logic [161:0]  snap_color;
   logic          snap_en, snap_blink, phase;
   logic [2:0]    snap_face;
   logic [FW-1:0] fcnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap_color <= '0; snap_en <= 1'b0; snap_face <= '0; snap_blink <= 1'b0;
         phase <= 1'b0; fcnt <= '0;
      end else if (beam_now.fs) begin
         snap_color <= color; snap_en <= hl_en; snap_face <= hl_face; snap_blink <= phase;
         if (fcnt == F_LAST) begin fcnt <= '0; phase <= ~phase; end
         else fcnt <= fcnt + 1'b1;
      end
   end

   beam_t [3:1]   beam_pipe;
   logic [HW-1:0] s1_cx;
   logic [VW-1:0] s1_cy;
   logic [2:0]    s2_code;
   logic          s2_bg;

   logic [4:0] ax, ay;
   face_t      fa;
   logic [7:0] sbit;
   logic       hide;

   always_comb begin
      ax   = axis_dec(int'(s1_cx) - ORIGIN_X);
      ay   = axis_dec(int'(s1_cy) - ORIGIN_Y);
      fa   = face_at(ax[3:2], ay[3:2]);
      sbit = 8'(3 * (int'(fa.face) * 9 + int'(ay[1:0]) * 3 + int'(ax[1:0])));
      hide = snap_blink && snap_en && (snap_face == fa.face);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beam_pipe <= {3{BEAM_RST}};
         s1_cx <= '0; s1_cy <= '0;
         s2_code <= '0; s2_bg <= 1'b1;
      end else begin
         beam_pipe <= {beam_pipe[2:1], beam_now};
         s1_cx <= hc;
         s1_cy <= vc;
         s2_code <= snap_color[sbit +: 3];
         s2_bg <= !(beam_pipe[1].active && ax[4] && ay[4] && fa.ok) || hide;
      end
   end

   logic [23:0] rgb;

   cube_palette #(.BG_RGB(BG_RGB)) u_palette (
      .clk      (clk),
      .rst      (rst),
      .code     (s2_code),
      .force_bg (s2_bg),
      .blank    (!beam_pipe[2].active),
      .rgb      (rgb)
   );

   assign {VGA_R, VGA_G, VGA_B} = rgb;
   assign VGA_HS      = beam_pipe[3].hs;
   assign VGA_VS      = beam_pipe[3].vs;
   assign VGA_BLANK_N = beam_pipe[3].active;
   assign frame_start = beam_pipe[3].fs;
   assign VGA_SYNC_N  = 1'b0;
   assign VGA_CLK     = clk;

endmodule

// File: tb/tb_cube_net_renderer.sv
// Randomized bench for cube_net_renderer on a shrunken raster, checked against a pixel-level model.
module tb_cube_net_renderer;

   localparam int HA = 77, HFP = 3, HSY = 5, HBP = 4;
   localparam int VA = 57, VFP = 2, VSY = 3, VBP = 2;
   localparam int CP = 2, ST = 2, GP = 1, OX = 1, OY = 1, BF = 2;
   localparam logic [23:0] BG = 24'h102030;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int FT = HT * VT;
   localparam int P  = ST + GP;
   localparam int FP = 3 * P + GP;
   localparam logic [29:0] RST_BUS = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [161:0] color = '0;
   logic         hl_en = 1'b0;
   logic [2:0]   hl_face = '0;
   logic [7:0]   r, g, b;
   logic         hs, vs, blank_n, sync_n, vclk, fs;
   logic [29:0]  bus;

   int checks = 0;
   int errors = 0;

   logic [161:0] snap_col  [16];
   logic         snap_en   [16];
   logic [2:0]   snap_face [16];
   logic [23:0]  pal [8] = '{24'hFFFFFF, 24'hFF4000, 24'h00FF00, 24'hFF0000,
                             24'h0000FF, 24'hFFFF00, 24'hFF00FF, 24'hFF00FF};

   always #5 clk = ~clk;

   cube_net_renderer #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .CELL_PX(CP), .STICKER_CELLS(ST), .GAP_CELLS(GP),
      .ORIGIN_X(OX), .ORIGIN_Y(OY), .BG_RGB(BG), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .rst(rst), .color(color), .hl_en(hl_en), .hl_face(hl_face),
      .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_HS(hs), .VGA_VS(vs),
      .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n), .VGA_CLK(vclk),
      .frame_start(fs)
   );

   assign bus = {r, g, b, hs, vs, blank_n, fs, sync_n, vclk};

   task automatic chk(input string tag, input logic [29:0] got, input logic [29:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Colour of an active pixel in frame f, straight from the net geometry.
   function automatic logic [23:0] pix(input int x, input int y, input int f);
      int lx, ly, gx, gy, fx, fy, face, k;
      lx = x / CP - OX;
      ly = y / CP - OY;
      if (lx < 0 || ly < 0) return BG;
      gx = lx / FP; gy = ly / FP;
      fx = lx % FP; fy = ly % FP;
      if (fx >= 3 * P || fy >= 3 * P || fx % P >= ST || fy % P >= ST) return BG;
      face = -1;
      if (gy == 0 && gx == 1)      face = 0;
      else if (gy == 1 && gx <= 3) face = 1 + gx;
      else if (gy == 2 && gx == 1) face = 5;
      if (face < 0) return BG;
      if ((f / BF) % 2 == 1 && snap_en[f] && int'(snap_face[f]) == face) return BG;
      k = face * 9 + (fy / P) * 3 + fx / P;
      return pal[snap_col[f][3 * k +: 3]];
   endfunction

   // Expected output bus e clocks after reset release (3-clock latency).
   function automatic logic [29:0] exp_bus(input int e);
      int p, x, y, f;
      logic act;
      logic [23:0] rgb;
      if (e < 3) return RST_BUS;
      p = e - 3;
      x = p % HT;
      y = (p / HT) % VT;
      f = p / FT;
      act = (x < HA) && (y < VA);
      rgb = act ? pix(x, y, f) : 24'h0;
      return {rgb, !(x >= HA + HFP && x < HA + HFP + HSY), !(y >= VA + VFP && y < VA + VFP + VSY),
              act, (x == 0) && (y == 0), 1'b0, 1'b0};
   endfunction

   task automatic rand_inputs();
      for (int i = 0; i < 54; i++) color[3 * i +: 3] = 3'($urandom_range(0, 7));
      hl_en   = ($urandom_range(0, 3) != 0);
      hl_face = 3'($urandom_range(0, 7));
   endtask

   task automatic rec(input int f);
      if (f % 4 == 2) begin
         hl_en   = 1'b1;
         hl_face = 3'($urandom_range(0, 5));
      end
      snap_col[f]  = color;
      snap_en[f]   = hl_en;
      snap_face[f] = hl_face;
   endtask

   // Release reset now and compare every clock for n clocks.
   task automatic run(input int n);
      rst = 1'b1;
      rec(0);
      for (int e = 1; e <= n; e++) begin
         @(negedge clk); #1;
         chk("px", bus, exp_bus(e));
         if ($urandom_range(0, 999) == 0) rand_inputs();
         if (e % FT == 0) rec(e / FT);
      end
   endtask

   initial begin
      rand_inputs();
      repeat (5) begin
         @(negedge clk); #1;
         chk("reset", bus, RST_BUS);
      end
      run(7 * FT + 1234);
      rst = 1'b0;
      #1 chk("rst_async", bus, RST_BUS);
      repeat (3) begin
         @(negedge clk); #1;
         chk("rst_hold", bus, RST_BUS);
      end
      rand_inputs();
      run(FT + 500);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
